fetch_cycle: RTL and testbench

- Instruction-fetch program-counter stage of the RV32IM pipeline.
- Holds the 32-bit PC register and selects the next PC from four sources: sequential PC+4, decode-stage branch/jump target, ALU-computed target, or hold.
- Presents the current PC and PC+4 to instruction memory and to downstream pipeline registers.

---
 rtl/fetch_cycle.sv | 59 +++++
 tb/tb_fetch_cycle.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fetch_cycle.sv
// fetch_cycle: program-counter stage of the instruction fetch.
// Holds the PC register and picks the next PC from sequential PC+step,
// the decode-stage target, the ALU target, or the current PC (hold).
// pc_out comes straight from the register; pc_plus4 depends only on it.
module fetch_cycle #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      pc_s_in,
  input  logic [XLEN-1:0] pc_dec_in,
  input  logic [XLEN-1:0] pc_alu_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4
);

  // Next-PC select encodings.
  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_DEC  = 2'b01;
  localparam logic [1:0] SEL_ALU  = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_inc;

  // Sequential successor; unsigned add wraps modulo 2^XLEN.
  assign pc_inc = pc_reg + STEP;

  // Next-PC mux. Unselected targets never reach the register, so X on an
  // unused target input cannot leak into the PC.
  always_comb begin
    pc_next = pc_reg;
    unique case (pc_s_in)
      SEL_SEQ:  pc_next = pc_inc;
      SEL_DEC:  pc_next = pc_dec_in;
      SEL_ALU:  pc_next = pc_alu_in;
      SEL_HOLD: pc_next = pc_reg;
      default:  pc_next = pc_reg;
    endcase
  end

  // PC register: reset forces RESET_PC at once and wins over any edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign pc_out   = pc_reg;
  assign pc_plus4 = pc_inc;

endmodule

// File: tb/tb_fetch_cycle.sv
// tb_fetch_cycle: directed steps with a scoreboard of expected PC values.
module tb_fetch_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_s_in;
  logic [31:0] pc_dec_in;
  logic [31:0] pc_alu_in;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;

  fetch_cycle #(.XLEN(32), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .pc_s_in  (pc_s_in),
    .pc_dec_in(pc_dec_in),
    .pc_alu_in(pc_alu_in),
    .pc_out   (pc_out),
    .pc_plus4 (pc_plus4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one select, push the expected PC, clock once, pop and compare.
  task automatic step(input string tag, input logic [1:0] sel,
                      input logic [31:0] dec, input logic [31:0] alu);
    logic [31:0] exp;
    pc_s_in   = sel;
    pc_dec_in = dec;
    pc_alu_in = alu;
    case (sel)
      2'b00:   model_pc = model_pc + 32'd4;
      2'b01:   model_pc = dec;
      2'b10:   model_pc = alu;
      default: model_pc = model_pc;
    endcase
    exp_q.push_back(model_pc);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check({tag, ".pc"}, pc_out, exp);
    check({tag, ".plus4"}, pc_plus4, exp + 32'd4);
    $display("step %-10s sel=%b pc_out=%h pc_plus4=%h", tag, sel, pc_out, pc_plus4);
  endtask

  initial begin
    rst = 1'b1;
    pc_s_in = 2'b00;
    pc_dec_in = 32'h0;
    pc_alu_in = 32'h0;
    model_pc = 32'h0;

    // Reset held across the edge at 5 ns; released at 7 ns.
    #1;
    check("rst.pc", pc_out, 32'h0);
    check("rst.plus4", pc_plus4, 32'h4);
    @(posedge clk);
    #1;
    check("rst_edge.pc", pc_out, 32'h0);
    check("rst_edge.plus4", pc_plus4, 32'h4);
    #1;
    rst = 1'b0;

    // Sequential
    for (int i = 0; i < 4; i++) step("seq", 2'b00, 32'h0, 32'h0);

    // Decode redirect to an odd address, then sequential
    step("dec", 2'b01, 32'h0000_001F, 32'hxxxx_xxxx);
    step("dec_seq", 2'b00, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
    step("dec_seq", 2'b00, 32'h0, 32'h0);

    // ALU redirect, then sequential
    step("alu", 2'b10, 32'hxxxx_xxxx, 32'h0000_0011);
    step("alu_seq", 2'b00, 32'h0, 32'h0);
    step("alu_seq", 2'b00, 32'h0, 32'h0);

    // Hold at 0x40 for three edges, then resume
    step("to40", 2'b01, 32'h0000_0040, 32'h0);
    for (int i = 0; i < 3; i++) step("hold", 2'b11, 32'h1234_5678, 32'h8765_4321);
    step("resume", 2'b00, 32'h0, 32'h0);

    // Wrap around the top of the address space
    step("wrap_ld", 2'b01, 32'hFFFF_FFFC, 32'h0);
    step("wrap", 2'b00, 32'h0, 32'h0);
    step("post_wrap", 2'b00, 32'h0, 32'h0);

    // Asynchronous reset pulse between edges
    step("pre_rst", 2'b10, 32'h0, 32'h0000_1000);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.pc", pc_out, 32'h0);
    check("async_rst.plus4", pc_plus4, 32'h4);
    $display("async rst pc_out=%h pc_plus4=%h", pc_out, pc_plus4);
    #1;
    rst = 1'b0;
    model_pc = 32'h0;
    step("after_rst", 2'b00, 32'h0, 32'h0);

    // Reset held across an edge with a redirect selected: reset wins
    pc_s_in = 2'b01;
    pc_dec_in = 32'hDEAD_BEE0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_wins.pc", pc_out, 32'h0);
    $display("rst over edge pc_out=%h", pc_out);
    rst = 1'b0;
    model_pc = 32'h0;
    step("rel", 2'b00, 32'h0, 32'h0);

    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
